// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the writeback requesters/issue stage and the register-file
// write arbiter. The master side is the requesters and the issue stage. The slave
// side is the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WORD  = 32,
    parameter int unsigned RADDR = 5
);
    localparam int unsigned NREG = 2 ** RADDR;

    logic [NREQ-1:0]       req_valid_i;
    logic [NREQ-1:0]       req_ready_o;
    logic [NREQ*RADDR-1:0] req_addr_i;
    logic [NREQ*WORD-1:0]  req_data_i;
    logic                  rsv_valid_i;
    logic [RADDR-1:0]      rsv_addr_i;
    logic [NREG-1:0]       w_reserve_o;
    logic [NREG-1:0]       wb_o;
    logic [WORD-1:0]       wb_data_o;
    logic                  busy_o;

    modport master (
        output req_valid_i, req_addr_i, req_data_i, rsv_valid_i, rsv_addr_i,
        input  req_ready_o, w_reserve_o, wb_o, wb_data_o, busy_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_data_i, rsv_valid_i, rsv_addr_i,
        output req_ready_o, w_reserve_o, wb_o, wb_data_o, busy_o
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single register-file write path. It issues one-hot
// reserve and writeback strobes that reach the cells one cycle after sampling.
// A requester is masked for any cycle in which its destination register is being
// reserved. The cell gives reserve priority and would otherwise drop the data.
module regfile_wb_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WORD  = 32,
    parameter int unsigned RADDR = 5
) (
    input logic                clk,
    input logic                rst,
    regfile_wb_arbiter_if.slave bus
);
    localparam int unsigned NREG = 2 ** RADDR;
    localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [RADDR-1:0] addr_a [NREQ];
    logic [WORD-1:0]  data_a [NREQ];
    logic [NREQ-1:0]  elig;

    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    gnt_idx;
    logic             gnt_found;
    logic             hs;
    logic [RADDR-1:0] gnt_addr;
    logic [WORD-1:0]  gnt_data;

    logic [NREG-1:0]  wb_q, wb_d;
    logic [NREG-1:0]  rsv_q, rsv_d;
    logic [WORD-1:0]  wb_data_q, wb_data_d;

    // Unpack the flat request buses and mask requesters that collide with a reserve.
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            addr_a[k] = bus.req_addr_i[k*RADDR +: RADDR];
            data_a[k] = bus.req_data_i[k*WORD +: WORD];
            elig[k]   = bus.req_valid_i[k] &&
                        !(bus.rsv_valid_i && (bus.rsv_addr_i == addr_a[k]) &&
                          (addr_a[k] != '0));
        end
    end

    // Pick the first eligible requester, starting the search at the pointer.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_found && elig[PW'(idx)]) begin
                gnt_found = 1'b1;
                gnt_idx   = PW'(idx);
            end
        end
    end

    // Ready and busy are combinational. Reset forces both low, so no handshake can occur.
    always_comb begin
        hs              = rst && gnt_found;
        gnt_addr        = addr_a[gnt_idx];
        gnt_data        = data_a[gnt_idx];
        bus.req_ready_o = '0;
        if (hs) bus.req_ready_o[gnt_idx] = 1'b1;
        bus.busy_o      = rst && (|bus.req_valid_i) && !hs;
    end

    // Next state: the pointer moves past the winner, and the output strobes are decoded.
    always_comb begin
        ptr_d     = ptr_q;
        wb_d      = '0;
        rsv_d     = '0;
        wb_data_d = wb_data_q;
        if (hs) begin
            ptr_d     = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + PW'(1);
            wb_data_d = gnt_data;
            // Register 0 is hardwired: accept the write but never strobe the cell.
            if (gnt_addr != '0) wb_d[gnt_addr] = 1'b1;
        end
        if (bus.rsv_valid_i && (bus.rsv_addr_i != '0)) rsv_d[bus.rsv_addr_i] = 1'b1;
    end

    // State registers. An asynchronous reset drops any pending strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q     <= '0;
            wb_q      <= '0;
            rsv_q     <= '0;
            wb_data_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            wb_q      <= wb_d;
            rsv_q     <= rsv_d;
            wb_data_q <= wb_data_d;
        end
    end

    // Drive the registered strobes to the cells.
    always_comb begin
        bus.wb_o        = wb_q;
        bus.w_reserve_o = rsv_q;
        bus.wb_data_o   = wb_data_q;
    end
endmodule
